// File: rtl/gbp_update_ctrl.sv
// gbp_update_ctrl: speculative global history and PHT update scheduler.
// Keeps the speculative history used to index the PHT, records each
// prediction's lookup index in an in-order in-flight queue, issues one
// registered PHT update per resolved branch, and repairs the history from
// the committed history on a misprediction.
// Optional build macro: GBP_STATS_EN adds saturating branch/mispredict counters.
//
// state   | meaning
// RUN     | normal operation: accept predictions, resolve oldest branch
// RECOVER | one cycle after a mispredict: no accepts, resolves are underflow
module gbp_update_ctrl #(
  parameter int HIST_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              pred_ready,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic [HIST_W-1:0] spec_history,
  output logic              pht_upd_valid,
  output logic [HIST_W-1:0] pht_upd_index,
  output logic              pht_upd_taken,
  output logic              mispredict,
`ifdef GBP_STATS_EN
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts,
`endif
  output logic              err_underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  function automatic logic [HIST_W-1:0] shift_h(input logic [HIST_W-1:0] h, input logic d);
    return {d, h[HIST_W-1:1]};
  endfunction

  state_t            state_q;
  logic [HIST_W-1:0] spec_q, commit_q, upd_index_q;
  logic              upd_valid_q, upd_taken_q, mis_q, err_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     rd_q, wr_q;
  logic [HIST_W-1:0] idx_mem  [DEPTH];
  logic              pred_mem [DEPTH];

  logic              resolve_ok, wrong, accept;
  logic [HIST_W-1:0] commit_d;

  // A resolve only counts when RUN and something is in flight; a wrong one
  // blocks the same-cycle accept because that branch is younger.
  assign resolve_ok = (state_q == RUN) && resolve_valid && (count_q != '0);
  assign wrong      = resolve_ok && (resolve_taken != pred_mem[rd_q]);
  assign pred_ready = (state_q == RUN) && ((count_q != FULL) || (resolve_ok && !wrong));
  assign accept     = pred_valid && pred_ready && !wrong;
  assign commit_d   = shift_h(commit_q, resolve_taken);

  assign spec_history  = spec_q;
  assign pht_upd_valid = upd_valid_q;
  assign pht_upd_index = upd_index_q;
  assign pht_upd_taken = upd_taken_q;
  assign mispredict    = mis_q;
  assign err_underflow = err_q;

  // Queue storage: entry written at the write pointer on every accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      idx_mem[wr_q]  <= spec_q;
      pred_mem[wr_q] <= pred_taken;
    end
  end

  // Control FSM with histories, queue pointers and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= RUN;
      spec_q      <= '0;
      commit_q    <= '0;
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      upd_valid_q <= 1'b0;
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      upd_valid_q <= resolve_ok;
      mis_q       <= wrong;
      if (resolve_valid && !resolve_ok) err_q <= 1'b1;
      if (resolve_ok) begin
        upd_index_q <= idx_mem[rd_q];
        upd_taken_q <= resolve_taken;
        commit_q    <= commit_d;
      end
      case (state_q)
        RUN: begin
          if (wrong) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            spec_q  <= commit_d;
            state_q <= RECOVER;
          end else begin
            if (resolve_ok) rd_q <= rd_q + 1'b1;
            if (accept) begin
              wr_q   <= wr_q + 1'b1;
              spec_q <= shift_h(spec_q, pred_taken);
            end
            if (accept && !resolve_ok)      count_q <= count_q + 1'b1;
            else if (!accept && resolve_ok) count_q <= count_q - 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef GBP_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve_ok && stat_branches != 16'hFFFF)  stat_branches    <= stat_branches + 16'd1;
      if (wrong && stat_mispredicts != 16'hFFFF)    stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gbp_update_ctrl.sv
// Testbench for gbp_update_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_gbp_update_ctrl;
  localparam int HW = 12;
  localparam int D  = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic pred_valid = 1'b0, pred_taken = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic pred_ready, pht_upd_valid, pht_upd_taken, mispredict, err_underflow;
  logic [HW-1:0] spec_history, pht_upd_index;
`ifdef GBP_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  gbp_update_ctrl #(.HIST_W(HW), .DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .spec_history(spec_history), .pht_upd_valid(pht_upd_valid),
    .pht_upd_index(pht_upd_index), .pht_upd_taken(pht_upd_taken),
    .mispredict(mispredict),
`ifdef GBP_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .err_underflow(err_underflow));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [HW-1:0] idx; logic pred; } ent_t;
  ent_t mq[$];
  logic [HW-1:0] m_spec, m_commit, e_uidx;
  logic m_rec, m_err, e_uv, e_ut, e_mis, rdy_obs, rdy_exp;
  int m_br, m_mp;

  function automatic logic [HW-1:0] sh(input logic [HW-1:0] h, input logic d);
    int v;
    v = int'(h) / 2 + (d ? (1 << (HW - 1)) : 0);
    return v[HW-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_spec = '0; m_commit = '0; e_uidx = '0;
    m_rec = 0; m_err = 0; e_uv = 0; e_ut = 0; e_mis = 0;
    m_br = 0; m_mp = 0;
  endtask

  // Drives one cycle of stimulus and advances the reference model.
  task automatic cycle(input logic pv, input logic pt, input logic rv, input logic rt);
    bit ok, wr_g, acc;
    pred_valid = pv; pred_taken = pt; resolve_valid = rv; resolve_taken = rt;
    #1;
    ok   = !m_rec && rv && (mq.size() > 0);
    wr_g = ok && (rt != mq[0].pred);
    rdy_exp = !m_rec && ((mq.size() < D) || (ok && !wr_g));
    rdy_obs = pred_ready;
    acc = pv && rdy_exp && !wr_g;
    @(posedge CLK);
    if (rv && !ok) m_err = 1;
    e_uv = ok; e_mis = wr_g;
    if (ok) begin
      e_uidx = mq[0].idx; e_ut = rt;
      void'(mq.pop_front());
      m_commit = sh(m_commit, rt);
      if (m_br < 65535) m_br++;
    end
    if (wr_g) begin
      mq.delete();
      m_spec = m_commit;
      m_rec = 1;
      if (m_mp < 65535) m_mp++;
    end else begin
      m_rec = 0;
      if (acc) begin
        mq.push_back('{idx: m_spec, pred: pt});
        m_spec = sh(m_spec, pt);
      end
    end
    #1;
    pred_valid = 0; resolve_valid = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #3;
    RESET = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({spec_history, pht_upd_valid, pht_upd_index, pht_upd_taken, mispredict, err_underflow, pred_ready}
        !== {12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values got spec=%h uv=%b ui=%h ut=%b mis=%b err=%b rdy=%b want 000 0 000 0 0 0 1",
               spec_history, pht_upd_valid, pht_upd_index, pht_upd_taken, mispredict, err_underflow, pred_ready);
    end
    RESET = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    logic [HW-1:0] want_s [3] = '{12'h800, 12'h400, 12'hA00};
    logic          dirs   [3] = '{1'b1, 1'b0, 1'b1};
    logic [HW-1:0] want_i [3] = '{12'h000, 12'h800, 12'h400};
    for (int i = 0; i < 3; i++) begin
      cycle(1, dirs[i], 0, 0);
      checks++;
      if (spec_history !== want_s[i] || rdy_obs !== 1'b1) begin
        errors++;
        $display("FAIL basic_accept%0d got spec=%h rdy=%b want %h 1", i, spec_history, rdy_obs, want_s[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, dirs[i]);
      checks++;
      if ({pht_upd_valid, pht_upd_index, pht_upd_taken, mispredict} !== {1'b1, want_i[i], dirs[i], 1'b0}) begin
        errors++;
        $display("FAIL basic_update%0d got v=%b i=%h t=%b mis=%b want 1 %h %b 0",
                 i, pht_upd_valid, pht_upd_index, pht_upd_taken, mispredict, want_i[i], dirs[i]);
      end
    end
    // Committed history is now 0xA00: a wrong taken resolve repairs to 0xD00.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 1);
    checks++;
    if ({mispredict, spec_history, pht_upd_valid, pht_upd_index} !== {1'b1, 12'hD00, 1'b1, 12'hA00}) begin
      errors++;
      $display("FAIL basic_repair got mis=%b spec=%h uv=%b ui=%h want 1 D00 1 A00",
               mispredict, spec_history, pht_upd_valid, pht_upd_index);
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (rdy_obs !== 1'b0 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL basic_recover got rdy=%b mis=%b want 0 0", rdy_obs, mispredict);
    end
  endtask

  task automatic test_full();
    logic [HW-1:0] s0;
    logic pt;
    for (int i = 0; i < D; i++) cycle(1, 1'($urandom_range(0, 1)), 0, 0);
    s0 = spec_history;
    cycle(1, 1, 0, 0);
    checks++;
    if (rdy_obs !== 1'b0 || spec_history !== s0) begin
      errors++;
      $display("FAIL full_block got rdy=%b spec=%h want 0 %h", rdy_obs, spec_history, s0);
    end
    pt = 1'($urandom_range(0, 1));
    cycle(1, pt, 1, mq[0].pred);
    checks++;
    if (rdy_obs !== 1'b1 || spec_history !== sh(s0, pt) || pht_upd_valid !== 1'b1 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop got rdy=%b spec=%h uv=%b mis=%b want 1 %h 1 0",
               rdy_obs, spec_history, pht_upd_valid, mispredict, sh(s0, pt));
    end
    cycle(1, 0, 0, 0);
    checks++;
    if (rdy_obs !== 1'b0 || mq.size() != D) begin
      errors++;
      $display("FAIL full_still got rdy=%b want 0", rdy_obs);
    end
    for (int i = 0; i < D; i++) begin
      cycle(0, 0, 1, mq[0].pred);
      checks++;
      if (pht_upd_valid !== 1'b1 || pht_upd_index !== e_uidx || pht_upd_taken !== e_ut) begin
        errors++;
        $display("FAIL full_drain%0d got v=%b i=%h t=%b want 1 %h %b",
                 i, pht_upd_valid, pht_upd_index, pht_upd_taken, e_uidx, e_ut);
      end
    end
  endtask

  task automatic test_mispredict();
    logic [HW-1:0] want;
    logic rt;
    for (int i = 0; i < 4; i++) cycle(1, 1'($urandom_range(0, 1)), 0, 0);
    rt = !mq[0].pred;
    want = sh(m_commit, rt);
    cycle(1, 1, 1, rt);
    checks++;
    if (mispredict !== 1'b1 || spec_history !== want || mq.size() != 0) begin
      errors++;
      $display("FAIL mis_pulse got mis=%b spec=%h want 1 %h", mispredict, spec_history, want);
    end
    cycle(1, 1, 0, 0);
    checks++;
    if (rdy_obs !== 1'b0 || mispredict !== 1'b0 || spec_history !== want) begin
      errors++;
      $display("FAIL mis_recover got rdy=%b mis=%b spec=%h want 0 0 %h", rdy_obs, mispredict, spec_history, want);
    end
    cycle(0, 0, 1, 1);
    checks++;
    if (pht_upd_valid !== 1'b0 || err_underflow !== 1'b1 || rdy_obs !== 1'b1) begin
      errors++;
      $display("FAIL mis_dropped got uv=%b err=%b rdy=%b want 0 1 1", pht_upd_valid, err_underflow, rdy_obs);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(0, 0, 1, 0);
    checks++;
    if (pht_upd_valid !== 1'b0 || err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow got uv=%b err=%b want 0 1", pht_upd_valid, err_underflow);
    end
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    cycle(0, 0, 1, mq[0].pred);
    checks++;
    if (err_underflow !== 1'b1 || pht_upd_valid !== 1'b1 || pht_upd_index !== 12'h000) begin
      errors++;
      $display("FAIL underflow_sticky got err=%b uv=%b ui=%h want 1 1 000", err_underflow, pht_upd_valid, pht_upd_index);
    end
  endtask

  task automatic test_random();
    logic pv, pt, rv, rt;
    for (int n = 0; n < 600; n++) begin
      pv = ($urandom_range(0, 9) < 6);
      pt = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 9) < 4);
      rt = (mq.size() > 0 && $urandom_range(0, 5) != 0) ? mq[0].pred : 1'($urandom_range(0, 1));
      cycle(pv, pt, rv, rt);
      checks++;
      if (rdy_obs !== rdy_exp || {spec_history, pht_upd_valid, mispredict, err_underflow} !== {m_spec, e_uv, e_mis, m_err}
          || (e_uv && {pht_upd_index, pht_upd_taken} !== {e_uidx, e_ut})) begin
        errors++;
        $display("FAIL random%0d got rdy=%b spec=%h uv=%b ui=%h ut=%b mis=%b err=%b want %b %h %b %h %b %b %b",
                 n, rdy_obs, spec_history, pht_upd_valid, pht_upd_index, pht_upd_taken, mispredict, err_underflow,
                 rdy_exp, m_spec, e_uv, e_uidx, e_ut, e_mis, m_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    cycle(0, 0, 1, mq[0].pred);
    pred_valid = 1; resolve_valid = 1; resolve_taken = mq[0].pred;
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if ({spec_history, pht_upd_valid, pht_upd_index, pht_upd_taken, mispredict, err_underflow, pred_ready}
        !== {12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got spec=%h uv=%b ui=%h ut=%b mis=%b err=%b rdy=%b want 000 0 000 0 0 0 1",
               spec_history, pht_upd_valid, pht_upd_index, pht_upd_taken, mispredict, err_underflow, pred_ready);
    end
    @(posedge CLK);
    #1;
    pred_valid = 0; resolve_valid = 0;
    RESET = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    cycle(0, 0, 1, 1);
    checks++;
    if (pht_upd_valid !== 1'b0 || err_underflow !== 1'b1 || spec_history !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_empty got uv=%b err=%b spec=%h want 0 1 000", pht_upd_valid, err_underflow, spec_history);
    end
  endtask

`ifdef GBP_STATS_EN
  task automatic test_stats();
    do_reset();
    cycle(1, 1, 0, 0); cycle(0, 0, 1, 1);
    cycle(1, 1, 0, 0); cycle(0, 0, 1, 1);
    cycle(1, 1, 0, 0); cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    checks++;
    if (stat_branches !== 16'd3 || stat_mispredicts !== 16'd1) begin
      errors++;
      $display("FAIL stats_count got br=%0d mp=%0d want 3 1", stat_branches, stat_mispredicts);
    end
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 65540; i++) cycle(1, 1, 1, 1);
    checks++;
    if (stat_branches !== 16'hFFFF || stat_mispredicts !== 16'd1 || m_br != 65535) begin
      errors++;
      $display("FAIL stats_sat got br=%h mp=%h want FFFF 0001", stat_branches, stat_mispredicts);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_underflow();
    test_random();
    test_reset_mid();
`ifdef GBP_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
